// File: rtl/im_loader.sv
// Byte-stream instruction-memory programmer: packs big-endian bytes into 32-bit words and writes IM from address 0.
// Optional trailing XOR checksum byte is enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int DataSize = 32,
  parameter int MemSize  = 1024,
  parameter int AddrSize = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic [AddrSize:0]   load_len,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                im_we,
  output logic [AddrSize-1:0] im_addr,
  output logic [DataSize-1:0] im_data,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [2:0]          dbg_state
);

  // Handshake: a byte moves on every rising edge where byte_valid && byte_ready;
  // the source must hold byte_data stable while byte_valid is high and byte_ready is low.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
`ifdef IM_LOADER_CHECKSUM_EN
    CHK     = 3'd3,
`endif
    DONE    = 3'd4
  } state_t;

  localparam logic [AddrSize:0] MemSizeL = (AddrSize+1)'(MemSize);

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [AddrSize:0]   word_cnt_q, word_cnt_d;
  logic [AddrSize:0]   len_q, len_d;
  logic [DataSize-1:0] shift_q, shift_d;
  logic                err_q, err_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      err_q      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      err_q      <= err_d;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    shift_d    = shift_q;
    err_d      = err_q;
`ifdef IM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    byte_ready = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          if (load_len == '0) begin
            state_d = DONE;
            err_d   = 1'b0;
          end else if (load_len > MemSizeL) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d    = COLLECT;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            len_d      = load_len;
            err_d      = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
          end
        end
      end
      COLLECT: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          shift_d    = {shift_q[DataSize-9:0], byte_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_data;
`endif
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_cnt_d == len_q) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = COLLECT;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CHK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          err_d   = (byte_data != csum_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Write port is driven straight from the counters so reset values fall out naturally.
  assign im_we     = (state_q == WRITE);
  assign im_addr   = word_cnt_q[AddrSize-1:0];
  assign im_data   = shift_q;
  assign load_done = (state_q == DONE);
  assign load_err  = err_q;
  assign cpu_hold  = !((state_q == DONE) && !err_q);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: expected IM writes come from a byte-list model packed big-endian.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [10:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int writes_seen = 0;

  logic [41:0] exp_q[$];
  logic [7:0]  stim_q[$];

  im_loader dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_data(im_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      logic [41:0] e;
      writes_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h", im_addr, im_data);
      end else begin
        e = exp_q.pop_front();
        if ({im_addr, im_data} !== e) begin
          bad++;
          $display("FAIL im_write got addr=%h data=%h exp addr=%h data=%h",
                   im_addr, im_data, e[41:32], e[31:0]);
        end
      end
    end
  end

  task automatic fill_random(input int nwords);
    stim_q.delete();
    for (int i = 0; i < 4 * nwords; i++) stim_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic start_load(input int len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = 11'(len);
    @(negedge clk);
    load_start = 1'b0;
    load_len   = 11'($urandom_range(0, 2047));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (byte_ready !== 1'b1) begin
      bad++;
      $display("FAIL byte_ready_timeout got=%b exp=1", byte_ready);
    end
    @(posedge clk);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (load_done !== 1'b1) begin
      bad++;
      $display("FAIL load_done_timeout got=%b exp=1", load_done);
    end
  endtask

  // Drives one load of the bytes in stim_q and checks the completion status.
  task automatic run_load(input int len, input int gap_max, input bit bad_csum, input bit poke_start);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      w = 32'(stim_q[4*i]) * 32'h0100_0000 + 32'(stim_q[4*i+1]) * 32'h0001_0000
        + 32'(stim_q[4*i+2]) * 32'h0000_0100 + 32'(stim_q[4*i+3]);
      exp_q.push_back({10'(i), w});
    end
    foreach (stim_q[i]) x = x ^ stim_q[i];
    writes_seen = 0;
    start_load(len);
    if (poke_start) begin
      @(negedge clk);
      load_start = 1'b1;
      load_len   = 11'd0;
      @(negedge clk);
      load_start = 1'b0;
    end
    foreach (stim_q[i]) send_byte(stim_q[i], $urandom_range(0, gap_max));
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (x ^ 8'h01) : x, $urandom_range(0, gap_max));
`endif
    @(negedge clk);
    byte_valid = 1'b0;
    wait_done(30000);
    repeat (3) @(negedge clk);
    total++;
`ifdef IM_LOADER_CHECKSUM_EN
    if (load_err !== bad_csum || cpu_hold !== bad_csum) begin
      bad++;
      $display("FAIL load_status got err=%b hold=%b exp err=%b hold=%b", load_err, cpu_hold, bad_csum, bad_csum);
    end
`else
    if (load_err !== 1'b0 || cpu_hold !== 1'b0 || load_done !== 1'b1) begin
      bad++;
      $display("FAIL load_status got err=%b hold=%b done=%b exp err=0 hold=0 done=1", load_err, cpu_hold, load_done);
    end
`endif
    total++;
    if (writes_seen != len || exp_q.size() != 0) begin
      bad++;
      $display("FAIL write_count got=%0d exp=%0d pending=%0d", writes_seen, len, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (byte_ready !== 1'b0 || im_we !== 1'b0 || im_addr !== 10'd0 || im_data !== 32'd0 ||
        cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL %s got rdy=%b we=%b addr=%h data=%h hold=%b done=%b err=%b exp 0 0 0 0 1 0 0",
               tag, byte_ready, im_we, im_addr, im_data, cpu_hold, load_done, load_err);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_basic;
    stim_q = '{8'h00, 8'h00, 8'h0D, 8'h13, 8'h00, 8'h00, 8'h0C, 8'h14};
    run_load(2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_toggle_valid;
    stim_q.delete();
    fill_random(1);
    writes_seen = 0;
    begin
      logic [31:0] w;
      w = 32'(stim_q[0]) * 32'h0100_0000 + 32'(stim_q[1]) * 32'h0001_0000
        + 32'(stim_q[2]) * 32'h0000_0100 + 32'(stim_q[3]);
      exp_q.push_back({10'd0, w});
    end
    start_load(1);
    foreach (stim_q[i]) send_byte(stim_q[i], 1);
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(stim_q[0] ^ stim_q[1] ^ stim_q[2] ^ stim_q[3], 1);
`endif
    @(negedge clk);
    byte_valid = 1'b0;
    wait_done(100);
    total++;
    if (writes_seen != 1 || exp_q.size() != 0 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL toggle_valid got writes=%0d err=%b exp writes=1 err=0", writes_seen, load_err);
    end
    exp_q.delete();
  endtask

  task automatic test_bad_len;
    writes_seen = 0;
    start_load(0);
    repeat (3) @(negedge clk);
    total++;
    if (load_done !== 1'b1 || load_err !== 1'b0 || cpu_hold !== 1'b0 || writes_seen != 0) begin
      bad++;
      $display("FAIL len_zero got done=%b err=%b hold=%b writes=%0d exp 1 0 0 0", load_done, load_err, cpu_hold, writes_seen);
    end
    start_load(1025);
    repeat (3) @(negedge clk);
    total++;
    if (load_done !== 1'b1 || load_err !== 1'b1 || cpu_hold !== 1'b1 || writes_seen != 0) begin
      bad++;
      $display("FAIL len_over got done=%b err=%b hold=%b writes=%0d exp 1 1 1 0", load_done, load_err, cpu_hold, writes_seen);
    end
  endtask

  task automatic test_random_loads;
    for (int k = 0; k < 6; k++) begin
      fill_random($urandom_range(1, 8));
      run_load(stim_q.size() / 4, $urandom_range(0, 3), 1'b0, 1'b0);
    end
  endtask

  task automatic test_ignore_start;
    fill_random(3);
    run_load(3, 1, 1'b0, 1'b1);
  endtask

  task automatic test_full_memory;
    fill_random(1024);
    run_load(1024, 0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset;
    fill_random(2);
    start_load(2);
    for (int i = 0; i < 3; i++) send_byte(stim_q[i], 0);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_load_reset");
    byte_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_mid_reset");
  endtask

`ifdef IM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    stim_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load(1, 0, 1'b0, 1'b0);
    stim_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load(1, 0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_toggle_valid();
    test_bad_len();
    test_random_loads();
    test_ignore_start();
`ifdef IM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_mid_reset();
    test_random_loads();
    test_full_memory();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
